// File: rtl/sync_req_arbiter.sv
`default_nettype none
// ============================================================================
// sync_req_arbiter : round-robin arbiter for async active-low requests with
//                    2-flop synchronizers, grant/done handshake and watchdog.
// Revision: 1.0
// ============================================================================
module sync_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 15,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req_n,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0]         C_CNT_LAST = 8'(HOLD_MAX - 1);
  localparam logic [NUM_REQ-1:0] C_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]    C_LAST_RST = ID_W'(NUM_REQ - 1);

  state_t             state_q;
  logic [NUM_REQ-1:0] s1_q;
  logic [NUM_REQ-1:0] s2_q;
  logic [ID_W-1:0]    last_q;
  logic [7:0]         cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               busy_q;
  logic               timeout_q;

  logic               pick_valid_d;
  logic [ID_W-1:0]    pick_idx_d;
  logic [ID_W-1:0]    cand_d;
  logic               exit_done_d;
  logic               exit_wdraw_d;
  logic               exit_wdog_d;
  logic               exit_d;
  logic               tmo_only_d;

  // Scan downward so the candidate nearest to last+1 is written last and wins.
  always_comb begin
    pick_valid_d = 1'b0;
    pick_idx_d   = '0;
    cand_d       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_d = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!s2_q[cand_d]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = cand_d;
      end
    end
  end

  always_comb begin
    exit_done_d  = done;
    exit_wdraw_d = s2_q[grant_id_q];
    exit_wdog_d  = (cnt_q == C_CNT_LAST);
    exit_d       = exit_done_d | exit_wdraw_d | exit_wdog_d;
    tmo_only_d   = exit_wdog_d & ~exit_done_d & ~exit_wdraw_d;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= '1;
      s2_q       <= '1;
      last_q     <= C_LAST_RST;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      s1_q      <= async_req_n;
      s2_q      <= s1_q;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_d) begin
            grant_q    <= C_ONE << pick_idx_d;
            grant_id_q <= pick_idx_d;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          cnt_q <= cnt_q + 8'd1;
          if (exit_d) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= tmo_only_d;
            state_q   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          last_q  <= grant_id_q;
          state_q <= ST_IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sync_req_arbiter : directed + random stimulus against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_sync_req_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int HOLD_MAX = 15;
  localparam int ID_W     = 2;

  logic               clk;
  logic               n_rst;
  logic [NUM_REQ-1:0] async_req_n;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout;

  int n_checks = 0;
  int n_errors = 0;

  sync_req_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_req_n (async_req_n),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, how long, and the dead time after release.
  bit   [NUM_REQ-1:0] m_s1, m_s2;
  int                 m_owner;
  int                 m_held;
  bit                 m_in_release;
  int                 m_last;
  int                 m_id;
  bit                 m_tout;
  bit                 chk_en = 1'b0;

  task automatic model_step();
    bit [NUM_REQ-1:0] seen;
    if (n_rst) begin
      m_s1 = '1; m_s2 = '1; m_owner = -1; m_held = 0; m_in_release = 0;
      m_last = NUM_REQ - 1; m_id = 0; m_tout = 0; chk_en = 1'b1;
      return;
    end
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = async_req_n;
    m_tout = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (done || seen[m_owner] || m_held == HOLD_MAX) begin
        m_tout = !done && !seen[m_owner];
        m_last = m_owner;
        m_owner = -1;
        m_in_release = 1;
      end
    end else if (m_in_release) begin
      m_in_release = 0;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (!seen[c]) begin
          m_owner = c; m_id = c; m_held = 0;
          break;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_grant",   32'(grant),    (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("m_grantid", 32'(grant_id), 32'(m_id));
      check("m_busy",    32'(busy),     32'(m_owner >= 0));
      check("m_timeout", 32'(timeout),  32'(m_tout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (grant != '0) begin ok = 1; break; end
      tick();
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    int exp_seq [6] = '{3, 0, 1, 2, 3, 0};
    int zeros;
    int held;

    n_rst = 1'b1; async_req_n = 4'b0000; done = 1'b0;
    repeat (3) begin
      tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy",  32'(busy),  32'd0);
    end
    n_rst = 1'b0; async_req_n = 4'b1111;
    repeat (4) begin
      tick();
      check("idle_grant",   32'(grant),    32'd0);
      check("idle_gid",     32'(grant_id), 32'd0);
      check("idle_timeout", 32'(timeout),  32'd0);
    end

    async_req_n = 4'b1011;
    tick(); tick();
    check("lat_early", 32'(grant), 32'd0);
    tick();
    check("lat_grant", 32'(grant), 32'b0100);
    check("lat_gid",   32'(grant_id), 32'd2);
    check("lat_busy",  32'(busy), 32'd1);
    tick();
    done = 1'b1; async_req_n = 4'b1111;
    tick();
    done = 1'b0;
    check("done_grant",   32'(grant), 32'd0);
    check("done_timeout", 32'(timeout), 32'd0);
    check("done_gidhold", 32'(grant_id), 32'd2);
    repeat (3) tick();

    async_req_n = 4'b0000;
    zeros = 0;
    for (int g = 0; g < 6; g++) begin
      bit ok;
      ok = (grant != '0);
      for (int c = 0; c < 40 && !ok; c++) begin
        tick();
        if (grant == '0) zeros++;
        else ok = 1;
      end
      check("rr_wait", 32'(ok), 32'd1);
      check("rr_gid",   32'(grant_id), 32'(exp_seq[g]));
      check("rr_grant", 32'(grant), 32'd1 << exp_seq[g]);
      if (g > 0) check("rr_gap", 32'(zeros), 32'd2);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      zeros = (grant == '0) ? 1 : 0;
    end
    async_req_n = 4'b1111; done = 1'b1;
    tick();
    done = 1'b0;
    repeat (4) tick();

    async_req_n = 4'b1101;
    wait_grant("wd_wait");
    held = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (grant == 4'b0010) held++;
      else break;
    end
    check("wd_len",     32'(held), 32'd15);
    check("wd_grant",   32'(grant), 32'd0);
    check("wd_timeout", 32'(timeout), 32'd1);
    async_req_n = 4'b1111;
    tick();
    check("wd_pulse", 32'(timeout), 32'd0);
    repeat (6) tick();

    async_req_n = 4'b1101;
    wait_grant("wdd_wait");
    repeat (14) tick();
    check("wdd_held", 32'(grant), 32'b0010);
    done = 1'b1; async_req_n = 4'b1111;
    tick();
    done = 1'b0;
    check("wdd_grant",   32'(grant), 32'd0);
    check("wdd_timeout", 32'(timeout), 32'd0);
    repeat (4) tick();

    async_req_n = 4'b0111;
    wait_grant("rm_wait");
    check("rm_owner", 32'(grant), 32'b1000);
    async_req_n = 4'b0110; n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    check("rm_grant", 32'(grant), 32'd0);
    check("rm_gid",   32'(grant_id), 32'd0);
    wait_grant("rm_wait2");
    check("rm_next", 32'(grant), 32'b0001);
    async_req_n = 4'b0111;
    tick();
    check("wdr_hold1", 32'(grant), 32'b0001);
    tick();
    check("wdr_hold2", 32'(grant), 32'b0001);
    tick();
    check("wdr_grant",   32'(grant), 32'd0);
    check("wdr_timeout", 32'(timeout), 32'd0);
    async_req_n = 4'b1111;
    repeat (6) tick();

    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < NUM_REQ; b++)
        if ($urandom_range(0, 7) == 0) async_req_n[b] = ~async_req_n[b];
      done  = ($urandom_range(0, 15) == 0);
      n_rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    n_rst = 1'b0; done = 1'b0; async_req_n = 4'b1111;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
